// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// Holds FSM states, BCD digit type, blank code and saturation limit.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_CODE = 4'hF;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic int unsigned max_dec(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value handshake between a numeric producer and the display controller.
// The producer drives value/blanking/valid; the controller answers with ready.
interface seg_scan_ctrl_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] bin_in;
    logic             blank_lz;
    logic             bin_valid;
    logic             bin_ready;

    modport master (
        output bin_in,
        output blank_lz,
        output bin_valid,
        input  bin_ready
    );

    modport slave (
        input  bin_in,
        input  blank_lz,
        input  bin_valid,
        output bin_ready
    );
endinterface

// File: rtl/bcd27s.sv
// BCD digit to active-low 7-segment glyph {g,f,e,d,c,b,a}.
// Codes 10..15 (including the blank code) turn every segment off.
module bcd27s
    import seg_pkg::*;
(
    input  bcd_digit_t  d,
    output logic [6:0]  seg
);

    // Glyph lookup; anything that is not a decimal digit is dark.
    always_comb begin
        seg = 7'h7F;
        unique case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble: one add-3/shift step per enabled cycle.
// done is high during the final step so the caller can move on.
module bin2bcd_dd
    import seg_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      din,
    input  logic                  step,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  done
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]      sh_bin;
    logic [4*N_DIGITS-1:0] sh_bcd;
    logic [4*N_DIGITS-1:0] adj;
    logic [CW-1:0]         cnt;

    // Add 3 to every nibble of 5 or more ahead of the shift.
    always_comb begin
        adj = sh_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register and remaining-step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bin <= '0;
            sh_bcd <= '0;
            cnt    <= '0;
        end else if (load) begin
            sh_bin <= din;
            sh_bcd <= '0;
            cnt    <= CW'(BIN_W);
        end else if (step && cnt != '0) begin
            {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
            cnt              <= cnt - 1'b1;
        end
    end

    assign bcd  = sh_bcd;
    assign done = step && (cnt == CW'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Binary-to-display controller: converts values to BCD and scans them
// onto a common-anode 7-segment display through one shared decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_ctrl_if.slave      bus,
    output logic                busy,
    output logic                ovf,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [BIN_W-1:0] LIMIT = BIN_W'(max_dec(N_DIGITS));

    state_t                state;
    state_t                nxt;
    logic                  load;
    logic                  step;
    logic                  commit;
    logic                  done;
    logic                  sat;
    logic [BIN_W-1:0]      din;
    logic [4*N_DIGITS-1:0] bcd;
    logic                  ovf_pend;
    logic                  blk;
    bcd_digit_t            shown [N_DIGITS];
    bcd_digit_t            disp  [N_DIGITS];
    logic                  seen;
    logic [SW-1:0]         scnt;
    logic [IW-1:0]         idx;
    logic [6:0]            dec_seg;

    assign bus.bin_ready = (state == IDLE) && !rst;
    assign busy          = !bus.bin_ready;
    assign sat           = bus.bin_in > LIMIT;
    assign din           = sat ? LIMIT : bus.bin_in;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next state and per-state strobes.
    always_comb begin
        nxt    = state;
        load   = 1'b0;
        step   = 1'b0;
        commit = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.bin_valid && bus.bin_ready) begin
                    load = 1'b1;
                    nxt  = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (done) nxt = COMMIT;
            end
            COMMIT: begin
                commit = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    bin2bcd_dd #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_dd (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .step (step),
        .bcd  (bcd),
        .done (done)
    );

    // Capture per-value flags at transfer; publish overflow at commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_pend <= 1'b0;
            blk      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (load) begin
                ovf_pend <= sat;
                blk      <= bus.blank_lz;
            end
            if (commit) ovf <= ovf_pend;
        end
    end

    // Blank zeros above the top nonzero digit; digit 0 always shows.
    always_comb begin
        seen  = 1'b0;
        shown = '{default: BLANK_CODE};
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            if (blk && !seen && i != 0) shown[i] = BLANK_CODE;
            else                        shown[i] = bcd[4*i +: 4];
        end
    end

    // Display registers, refreshed only at commit.
    always_ff @(posedge clk) begin
        if (rst)         disp <= '{default: BLANK_CODE};
        else if (commit) disp <= shown;
    end

    bcd27s u_dec (
        .d   (disp[idx]),
        .seg (dec_seg)
    );

    // Free-running scanner; seg and an are registered from the same idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
            idx  <= '0;
            seg  <= 7'h7F;
            an   <= '1;
        end else begin
            seg <= dec_seg;
            an  <= ~(N_DIGITS'(1) << idx);
            if (scnt == SW'(SCAN_DIV - 1)) begin
                scnt <= '0;
                idx  <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scnt <= scnt + 1'b1;
            end
        end
    end

endmodule
